reg_shift_ctrl: RTL and testbench

Sequencer for the 8-bit load/shift register `REG`. It accepts a byte and a bit count through a start handshake, loads the register, and clocks out 1–8 bits MSB-first on `sout`. At the same time it shifts `sin` in at bit 0. The received bits are returned with a one-cycle `done` pulse. It sits between the ALU's control path and any serial peripheral or bit-serial datapath stage that needs the register time-shared under a single owner.

---
 rtl/reg_pkg.sv | 21 ++
 rtl/reg_shift_ctrl_reg.sv | 26 ++
 rtl/reg_shift_ctrl.sv | 115 +++++++++++
 tb/tb_reg_shift_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared types for the load/shift register sequencer.
// No logic: state encoding, widths and a start_len legality helper.
// No flow control of its own.
package reg_pkg;

    localparam int REG_W = 8;
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A transfer moves between 1 and REG_W bits.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(REG_W));
    endfunction

endpackage

// File: rtl/reg_shift_ctrl_reg.sv
// 8-bit load/shift register: parallel load, or shift left with d0 entering at bit 0.
// Latency: one edge from load/shift to q.
// No backpressure; load wins over shift, and q holds when neither is asserted.
module reg_shift_ctrl_reg
    import reg_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             shift,
    input  logic [REG_W-1:0] load_data,
    input  logic             d0,
    output logic [REG_W-1:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[REG_W-2:0], d0};
        end
    end

endmodule

// File: rtl/reg_shift_ctrl.sv
// Sequencer that loads REG, then shifts 1..8 bits out on sout (MSB first) while taking sin in.
// Latency: start to ready is len*DIV + 3 cycles; done is a one-cycle pulse.
// Backpressure: start is taken only while ready; a start at any other time is dropped, not queued.
module reg_shift_ctrl
    import reg_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [REG_W-1:0] start_data,
    input  logic [LEN_W-1:0] start_len,
    input  logic             abort,
    input  logic             sin,
    output logic             sout,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] rx_data,
    output logic             err
);

    localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt;
    logic [REG_W-1:0] data_q;
    logic [7:0]       div_cnt;
    logic             err_q;

    logic             reg_load;
    logic             reg_shift;
    logic [REG_W-1:0] reg_q;

    // Abort suppresses the register update in its cycle so Q keeps its value.
    assign reg_load  = (state == LOAD) && !abort;
    assign reg_shift = (state == SHIFT) && (div_cnt == '0) && !abort;

    reg_shift_ctrl_reg u_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load      (reg_load),
        .shift     (reg_shift),
        .load_data (data_q),
        .d0        (sin),
        .q         (reg_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            len_q   <= '0;
            bit_cnt <= '0;
            data_q  <= '0;
            div_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_legal(start_len)) begin
                            data_q <= start_data;
                            len_q  <= start_len;
                            state  <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        bit_cnt <= len_q;
                        div_cnt <= DIV_RELOAD;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (div_cnt == '0) begin
                        bit_cnt <= bit_cnt - LEN_W'(1);
                        div_cnt <= DIV_RELOAD;
                        if (bit_cnt == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sout    = reg_q[REG_W-1];
    assign ready   = (state == IDLE);
    assign busy    = (state == LOAD) || (state == SHIFT);
    assign done    = (state == DONE);
    assign rx_data = (state == DONE) ? reg_q : '0;
    assign err     = err_q;

    // err can only rise out of IDLE, done only out of SHIFT, so they never overlap.
    a_done_err_exclusive: assert property (@(posedge clk) disable iff (!resetn) !(done && err));

endmodule

// File: tb/tb_reg_shift_ctrl.sv
// Scoreboard bench for reg_shift_ctrl: one DIV=1 instance and one DIV=3 instance.
// Expected rx_data values are queued at start and popped when done is seen.
module tb_reg_shift_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start1, start3;
    logic [7:0] start_data;
    logic [3:0] start_len;
    logic       abort;
    logic       sin;

    logic       sout1, ready1, busy1, done1, err1;
    logic [7:0] rx1;
    logic       sout3, ready3, busy3, done3, err3;
    logic [7:0] rx3;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp1_q[$];
    logic [7:0] exp3_q[$];

    always #5 clk = ~clk;

    reg_shift_ctrl #(.DIV(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .start_data(start_data),
        .start_len(start_len), .abort(abort), .sin(sin), .sout(sout1),
        .ready(ready1), .busy(busy1), .done(done1), .rx_data(rx1), .err(err1)
    );

    reg_shift_ctrl #(.DIV(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start3), .start_data(start_data),
        .start_len(start_len), .abort(abort), .sin(sin), .sout(sout3),
        .ready(ready3), .busy(busy3), .done(done3), .rx_data(rx3), .err(err3)
    );

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [7:0] e;
        if (resetn) begin
            if (done1) begin
                tests++;
                if (exp1_q.size() == 0) begin
                    fails++;
                    $display("FAIL done1_unexpected rx_data=%02h required no done", rx1);
                end else begin
                    e = exp1_q.pop_front();
                    if (rx1 !== e) begin
                        fails++;
                        $display("FAIL rx_data1 got=%02h exp=%02h", rx1, e);
                    end
                end
            end
            if (done3) begin
                tests++;
                if (exp3_q.size() == 0) begin
                    fails++;
                    $display("FAIL done3_unexpected rx_data=%02h required no done", rx3);
                end else begin
                    e = exp3_q.pop_front();
                    if (rx3 !== e) begin
                        fails++;
                        $display("FAIL rx_data3 got=%02h exp=%02h", rx3, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start1 = 1'b0; start3 = 1'b0; start_data = 8'h00;
        start_len = 4'd0; abort = 1'b0; sin = 1'b0;
        #3;
        tests++;
        if ({ready1, busy1, done1, err1, sout1, rx1} !== {5'b10000, 8'h00}) begin
            fails++;
            $display("FAIL reset_outputs1 got=%b exp=%b", {ready1, busy1, done1, err1, sout1, rx1}, {5'b10000, 8'h00});
        end
        tests++;
        if ({ready3, busy3, done3, err3, sout3, rx3} !== {5'b10000, 8'h00}) begin
            fails++;
            $display("FAIL reset_outputs3 got=%b exp=%b", {ready3, busy3, done3, err3, sout3, rx3}, {5'b10000, 8'h00});
        end
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    // One DIV=1 transfer; sin_seq holds the bits to shift in, first bit at [7].
    task automatic run1(input logic [7:0] data, input logic [3:0] len,
                        input logic [7:0] sin_seq, input logic [7:0] exp_rx, input int inject_at);
        start1 = 1'b1; start_data = data; start_len = len;
        tests++;
        if (ready1 !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_start got=%b exp=1", ready1);
        end
        tick();
        start1 = 1'b0;
        exp1_q.push_back(exp_rx);
        @(negedge clk);
        tests++;
        if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
            fails++;
            $display("FAIL busy_in_load busy=%b ready=%b exp busy=1 ready=0", busy1, ready1);
        end
        tick();
        for (int k = 1; k <= int'(len); k++) begin
            sin = sin_seq[8-k];
            if (k == inject_at) begin
                start1 = 1'b1; start_data = 8'hFF; start_len = 4'd3;
            end
            @(negedge clk);
            tests++;
            if (sout1 !== data[8-k]) begin
                fails++;
                $display("FAIL sout_bit%0d got=%b exp=%b", k, sout1, data[8-k]);
            end
            tick();
            start1 = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (done1 !== 1'b1) begin
            fails++;
            $display("FAIL done_timing got=%b exp=1", done1);
        end
        tick();
        tests++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            fails++;
            $display("FAIL ready_after_done ready=%b busy=%b done=%b exp 1 0 0", ready1, busy1, done1);
        end
        @(negedge clk);
        tests++;
        if (busy1 !== 1'b0) begin
            fails++;
            $display("FAIL start_not_queued busy=%b exp=0", busy1);
        end
        tick();
    endtask

    task automatic test_len2();
        run1(8'hEB, 4'd2, 8'h80, 8'hAE, 0);
    endtask

    task automatic test_len8_ignore_start();
        run1(8'h59, 4'd8, 8'hA5, 8'hA5, 4);
    endtask

    task automatic test_div3();
        start3 = 1'b1; start_data = 8'h80; start_len = 4'd1; sin = 1'b1;
        tick();
        start3 = 1'b0;
        exp3_q.push_back(8'h01);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (done3 !== 1'b0 || busy3 !== 1'b1) begin
                fails++;
                $display("FAIL div3_wait%0d done=%b busy=%b exp 0 1", c, done3, busy3);
            end
            if (c > 0) begin
                tests++;
                if (sout3 !== 1'b1) begin
                    fails++;
                    $display("FAIL div3_sout%0d got=%b exp=1", c, sout3);
                end
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (done3 !== 1'b1) begin
            fails++;
            $display("FAIL div3_done_timing got=%b exp=1", done3);
        end
        tick();
        tests++;
        if (ready3 !== 1'b1) begin
            fails++;
            $display("FAIL div3_ready got=%b exp=1", ready3);
        end
        sin = 1'b0;
    endtask

    task automatic test_err();
        logic [3:0] bad [2];
        bad[0] = 4'd0;
        bad[1] = 4'd9;
        for (int i = 0; i < 2; i++) begin
            start1 = 1'b1; start_data = 8'h3C; start_len = bad[i];
            tick();
            start1 = 1'b0;
            @(negedge clk);
            tests++;
            if (err1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
                fails++;
                $display("FAIL err_pulse_len%0d err=%b busy=%b ready=%b exp 1 0 1", bad[i], err1, busy1, ready1);
            end
            tick();
            @(negedge clk);
            tests++;
            if (err1 !== 1'b0 || ready1 !== 1'b1) begin
                fails++;
                $display("FAIL err_width_len%0d err=%b ready=%b exp 0 1", bad[i], err1, ready1);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        start1 = 1'b1; start_data = 8'h59; start_len = 4'd8; sin = 1'b1;
        repeat (5) begin
            tick();
            start1 = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        tests++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle ready=%b busy=%b done=%b exp 1 0 0", ready1, busy1, done1);
        end
        tests++;
        if (dut1.u_reg.q !== 8'hCF) begin
            fails++;
            $display("FAIL abort_q got=%02h exp=cf", dut1.u_reg.q);
        end
        repeat (2) tick();
        tests++;
        if (dut1.u_reg.q !== 8'hCF || done1 !== 1'b0) begin
            fails++;
            $display("FAIL abort_hold q=%02h done=%b exp cf 0", dut1.u_reg.q, done1);
        end
        sin = 1'b0;
    endtask

    task automatic test_reset_mid();
        start1 = 1'b1; start_data = 8'hFF; start_len = 4'd8; sin = 1'b0;
        repeat (4) begin
            tick();
            start1 = 1'b0;
        end
        tests++;
        if (busy1 !== 1'b1 || sout1 !== 1'b1) begin
            fails++;
            $display("FAIL midshift_precond busy=%b sout=%b exp 1 1", busy1, sout1);
        end
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if ({ready1, busy1, done1, err1, sout1, rx1} !== {5'b10000, 8'h00}) begin
            fails++;
            $display("FAIL midshift_reset got=%b exp=%b", {ready1, busy1, done1, err1, sout1, rx1}, {5'b10000, 8'h00});
        end
        tick();
        resetn = 1'b1;
        tick();
        run1(8'hEB, 4'd2, 8'h80, 8'hAE, 0);
    endtask

    initial begin
        test_reset();
        test_len2();
        test_len8_ignore_start();
        test_div3();
        test_err();
        test_abort();
        test_reset_mid();
        repeat (2) tick();
        tests++;
        if (exp1_q.size() != 0 || exp3_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain pending1=%0d pending3=%0d exp 0 0", exp1_q.size(), exp3_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
